// File: rtl/data_mem_resp_if.sv
// Request/response bundle between the core's load/store path (master)
// and the data-memory responder (slave).
interface data_mem_resp_if;
    logic        req_valid;
    logic        req_ready;
    logic        MemRW;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        resp_valid;
    logic [31:0] rdata;
    logic        misalign;

    modport master (
        output req_valid, MemRW, funct3, addr, wdata,
        input  req_ready, resp_valid, rdata, misalign
    );

    modport slave (
        input  req_valid, MemRW, funct3, addr, wdata,
        output req_ready, resp_valid, rdata, misalign
    );
endinterface

// File: rtl/data_mem_resp.sv
// Data-memory responder: accepts one load/store at a time, waits
// WAIT_STATES cycles, then issues a one-cycle response. Word-organised
// array with byte/half/word lanes and sign/zero extension.
// Optional feature macro: MISALIGN_TRAP_EN (flag and suppress misaligned
// half/word accesses instead of silently aligning them).
module data_mem_resp #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic             clk,
    input  logic             rst,
    data_mem_resp_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0] CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    state_t                state;
    logic [3:0]            cnt;
    logic                  op_store;
    logic [2:0]            op_f3;
    logic [ADDR_WIDTH+1:0] op_addr;
    logic [31:0]           op_wdata;

    logic [31:0]           mem [0:(1 << ADDR_WIDTH) - 1];

    logic                  cur_store;
    logic [2:0]            cur_f3;
    logic [ADDR_WIDTH+1:0] cur_addr;
    logic [31:0]           cur_wdata;
    logic [ADDR_WIDTH+1:0] eff_addr;
    logic [ADDR_WIDTH-1:0] idx;
    logic [1:0]            lane;
    logic                  is_half;
    logic                  is_word;
    logic                  legal;
    logic                  mis_hit;
    logic [31:0]           rd_word;
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;
    logic [31:0]           load_data;
    logic [3:0]            be;
    logic [31:0]           wr_word;
    logic                  enter_resp;

    // Upper address bits wrap away; they are deliberately unused.
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.addr[31:ADDR_WIDTH+2];

    // With zero wait states the response is computed on the accept edge,
    // before the request registers are loaded, so read the bus directly.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and a latch is never inferred.
        cur_store = op_store;
        cur_f3    = op_f3;
        cur_addr  = op_addr;
        cur_wdata = op_wdata;
        if (state == IDLE) begin
            cur_store = bus.MemRW;
            cur_f3    = bus.funct3;
            cur_addr  = bus.addr[ADDR_WIDTH+1:0];
            cur_wdata = bus.wdata;
        end
    end

    // Decode access size, legality, alignment and the effective address.
    always_comb begin
        is_half  = (cur_f3[1:0] == 2'b01);
        is_word  = (cur_f3[1:0] == 2'b10);
        legal    = cur_store ? (cur_f3 inside {3'b000, 3'b001, 3'b010})
                             : (cur_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        eff_addr = cur_addr;
`ifdef MISALIGN_TRAP_EN
        mis_hit  = legal && ((is_half && cur_addr[0]) || (is_word && (cur_addr[1:0] != 2'b00)));
`else
        mis_hit  = 1'b0;
        if (is_half) eff_addr[0]   = 1'b0;
        if (is_word) eff_addr[1:0] = 2'b00;
`endif
        idx      = eff_addr[ADDR_WIDTH+1:2];
        lane     = eff_addr[1:0];
    end

    // Lane selection and extension for loads; byte enables for stores.
    always_comb begin
        rd_word   = mem[idx];
        byte_sel  = 8'(rd_word >> {lane, 3'b000});
        half_sel  = lane[1] ? rd_word[31:16] : rd_word[15:0];
        load_data = 32'd0;
        be        = 4'b0000;
        wr_word   = cur_wdata;
        if (legal && !mis_hit) begin
            if (cur_store) begin
                case (cur_f3[1:0])
                    2'b00: begin
                        be      = 4'b0001 << lane;
                        wr_word = {4{cur_wdata[7:0]}};
                    end
                    2'b01: begin
                        be      = lane[1] ? 4'b1100 : 4'b0011;
                        wr_word = {2{cur_wdata[15:0]}};
                    end
                    default: be = 4'b1111;
                endcase
            end else begin
                case (cur_f3)
                    3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
                    3'b100:  load_data = {24'd0, byte_sel};
                    3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
                    3'b101:  load_data = {16'd0, half_sel};
                    default: load_data = rd_word;
                endcase
            end
        end
    end

    assign enter_resp = ((state == IDLE) && bus.req_valid && (WAIT_STATES == 0)) ||
                        ((state == WAIT) && (cnt == 4'd0));

    // Request FSM with registered handshake and response outputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state          <= IDLE;
            cnt            <= 4'd0;
            op_store       <= 1'b0;
            op_f3          <= 3'd0;
            op_addr        <= '0;
            op_wdata       <= 32'd0;
            bus.req_ready  <= 1'b1;
            bus.resp_valid <= 1'b0;
            bus.rdata      <= 32'd0;
            bus.misalign   <= 1'b0;
        end else begin
            bus.resp_valid <= 1'b0;
            if (enter_resp) begin
                bus.resp_valid <= 1'b1;
                bus.rdata      <= load_data;
                bus.misalign   <= mis_hit;
            end
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        op_store      <= bus.MemRW;
                        op_f3         <= bus.funct3;
                        op_addr       <= bus.addr[ADDR_WIDTH+1:0];
                        op_wdata      <= bus.wdata;
                        bus.req_ready <= 1'b0;
                        cnt           <= CNT_INIT;
                        state         <= (WAIT_STATES == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) state <= RESP;
                    else             cnt   <= cnt - 4'd1;
                end
                default: begin
                    state         <= IDLE;
                    bus.req_ready <= 1'b1;
                end
            endcase
        end
    end

    // Store commit on the edge entering RESP; reset cancels a pending write.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset; clearing it would forbid RAM mapping
        // and software never relies on its power-up contents.
        if (!rst && enter_resp) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][i*8 +: 8] <= wr_word[i*8 +: 8];
            end
        end
    end
endmodule

// File: tb/tb_data_mem_resp.sv
// Self-checking bench for data_mem_resp: one instance with two wait
// states and one with zero wait states, scoreboard-checked responses.
module tb_data_mem_resp;
    localparam int W2 = 2;
    localparam int W0 = 0;

    typedef struct {
        logic [31:0] rd;
        logic        mis;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    data_mem_resp_if bus2 ();
    data_mem_resp_if bus0 ();

    data_mem_resp #(.ADDR_WIDTH(10), .WAIT_STATES(W2)) dut (.clk(clk), .rst(rst), .bus(bus2));
    data_mem_resp #(.ADDR_WIDTH(10), .WAIT_STATES(W0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

    always #5 clk = ~clk;

    function automatic logic get_rv(int sel);
        return (sel == 1) ? bus0.resp_valid : bus2.resp_valid;
    endfunction
    function automatic logic get_rdy(int sel);
        return (sel == 1) ? bus0.req_ready : bus2.req_ready;
    endfunction
    function automatic logic [31:0] get_rd(int sel);
        return (sel == 1) ? bus0.rdata : bus2.rdata;
    endfunction
    function automatic logic get_mis(int sel);
        return (sel == 1) ? bus0.misalign : bus2.misalign;
    endfunction

    task automatic drive(input int sel, input logic v, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        if (sel == 1) begin
            bus0.req_valid = v; bus0.MemRW = st; bus0.funct3 = f3; bus0.addr = a; bus0.wdata = wd;
        end else begin
            bus2.req_valid = v; bus2.MemRW = st; bus2.funct3 = f3; bus2.addr = a; bus2.wdata = wd;
        end
    endtask

    // One complete transaction: drive, push expectation, wait bounded for
    // the response, check latency and handshake, pop and compare.
    task automatic access(input int sel, input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_mis,
                          input string name);
        int   lat;
        int   exp_lat;
        bit   got;
        exp_t e;
        exp_lat = (sel == 1) ? W0 + 1 : W2 + 1;
        @(negedge clk);
        n_checks++;
        if (get_rdy(sel) !== 1'b1) begin
            n_fail++; $display("FAIL %s ready_before: got %b expected 1", name, get_rdy(sel));
        end
        drive(sel, 1'b1, st, f3, a, wd);
        sb.push_back('{exp_rd, exp_mis, name});
        @(posedge clk); #1;
        drive(sel, 1'b0, $urandom_range(0, 1), 3'($urandom), $urandom, $urandom);
        got = 0; lat = 0;
        for (int k = 1; k <= 20 && !got; k++) begin
            @(negedge clk);
            if (get_rv(sel) === 1'b1) begin got = 1; lat = k; end
        end
        n_checks++;
        if (!got) begin
            n_fail++; $display("FAIL %s timeout: no resp_valid in 20 cycles", name);
            void'(sb.pop_front());
        end else begin
            if (lat !== exp_lat) begin
                n_fail++; $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
            end
            e = sb.pop_front();
            n_checks++;
            if (get_rd(sel) !== e.rd) begin
                n_fail++; $display("FAIL %s rdata: got %h expected %h", e.name, get_rd(sel), e.rd);
            end
            n_checks++;
            if (get_mis(sel) !== e.mis) begin
                n_fail++; $display("FAIL %s misalign: got %b expected %b", e.name, get_mis(sel), e.mis);
            end
            n_checks++;
            if (get_rdy(sel) !== 1'b0) begin
                n_fail++; $display("FAIL %s ready_in_resp: got %b expected 0", name, get_rdy(sel));
            end
            @(negedge clk);
            n_checks++;
            if (get_rv(sel) !== 1'b0 || get_rdy(sel) !== 1'b1) begin
                n_fail++;
                $display("FAIL %s after_resp: got valid=%b ready=%b expected valid=0 ready=1",
                         name, get_rv(sel), get_rdy(sel));
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            n_checks++;
            if (get_rdy(s) !== 1'b1 || get_rv(s) !== 1'b0 || get_rd(s) !== 32'd0 || get_mis(s) !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_state[%0d]: got ready=%b valid=%b rdata=%h mis=%b expected 1 0 0 0",
                         s, get_rdy(s), get_rv(s), get_rd(s), get_mis(s));
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_word();
        access(0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, "sw_10");
        access(0, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "lw_10");
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus2.rdata !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL rdata_hold: got %h expected deadbeef", bus2.rdata);
        end
    endtask

    task automatic test_byte_lanes();
        access(0, 1'b1, 3'b000, 32'h13, 32'h00000080, 32'h0, 1'b0, "sb_13");
        access(0, 1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0, "lb_13");
        access(0, 1'b0, 3'b100, 32'h13, 32'h0, 32'h00000080, 1'b0, "lbu_13");
        access(0, 1'b0, 3'b101, 32'h12, 32'h0, 32'h000080AD, 1'b0, "lhu_12");
        access(0, 1'b0, 3'b001, 32'h10, 32'h0, 32'hFFFFBEEF, 1'b0, "lh_10");
        access(0, 1'b0, 3'b000, 32'h11, 32'h0, 32'hFFFFFFBE, 1'b0, "lb_11");
        access(0, 1'b1, 3'b001, 32'h12, 32'hFFFF1234, 32'h0, 1'b0, "sh_12");
        access(0, 1'b0, 3'b010, 32'h10, 32'h0, 32'h1234BEEF, 1'b0, "lw_after_sh");
    endtask

    task automatic test_wrap();
        access(0, 1'b1, 3'b010, 32'h1000, 32'h12345678, 32'h0, 1'b0, "sw_1000");
        access(0, 1'b0, 3'b010, 32'h0000, 32'h0, 32'h12345678, 1'b0, "lw_0_wrap");
    endtask

    task automatic test_illegal();
        access(0, 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b0, "ld_illegal");
        access(0, 1'b1, 3'b011, 32'h10, 32'hFFFFFFFF, 32'h0, 1'b0, "st_illegal_011");
        access(0, 1'b1, 3'b101, 32'h10, 32'hFFFFFFFF, 32'h0, 1'b0, "st_illegal_101");
        access(0, 1'b0, 3'b010, 32'h10, 32'h0, 32'h1234BEEF, 1'b0, "lw_after_illegal");
    endtask

    task automatic test_misalign();
`ifdef MISALIGN_TRAP_EN
        access(0, 1'b0, 3'b010, 32'h11, 32'h0, 32'h0, 1'b1, "lw_11_trap");
        access(0, 1'b1, 3'b001, 32'h11, 32'h0000AAAA, 32'h0, 1'b1, "sh_11_trap");
        access(0, 1'b0, 3'b010, 32'h10, 32'h0, 32'h1234BEEF, 1'b0, "lw_10_unchanged");
`else
        access(0, 1'b0, 3'b010, 32'h11, 32'h0, 32'h1234BEEF, 1'b0, "lw_11_aligned");
        access(0, 1'b1, 3'b001, 32'h11, 32'h0000AAAA, 32'h0, 1'b0, "sh_11_aligned");
        access(0, 1'b0, 3'b010, 32'h10, 32'h0, 32'h1234AAAA, 1'b0, "lw_10_after_sh");
`endif
    endtask

    // Three loads with req_valid held high: one response every W2+2 cycles.
    task automatic test_back_to_back();
        int   pos[$];
        exp_t e;
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 3'b010, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) sb.push_back('{32'h12345678, 1'b0, "b2b_lw"});
        @(posedge clk);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (bus2.resp_valid === 1'b1) begin
                pos.push_back(k);
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++; $display("FAIL b2b_extra: unexpected response at cycle %0d", k);
                end else begin
                    e = sb.pop_front();
                    if (bus2.rdata !== e.rd) begin
                        n_fail++; $display("FAIL %s rdata: got %h expected %h", e.name, bus2.rdata, e.rd);
                    end
                end
            end
            if (k == 9) drive(0, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
        end
        n_checks++;
        if (pos.size() != 3) begin
            n_fail++; $display("FAIL b2b_count: got %0d responses expected 3", pos.size());
        end else if (pos[0] != W2 + 1 || pos[1] - pos[0] != W2 + 2 || pos[2] - pos[1] != W2 + 2) begin
            n_fail++;
            $display("FAIL b2b_spacing: got cycles %0d %0d %0d expected 3 7 11", pos[0], pos[1], pos[2]);
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++; n_fail++;
            $display("FAIL %s missing: got no response expected %h", e.name, e.rd);
        end
    endtask

    task automatic test_zero_wait();
        access(1, 1'b1, 3'b010, 32'h4, 32'hCAFEF00D, 32'h0, 1'b0, "zw_sw");
        // Load accepted; a store is then held on the bus during RESP and must be ignored.
        @(negedge clk);
        drive(1, 1'b1, 1'b0, 3'b010, 32'h4, 32'h0);
        @(posedge clk); #1;
        drive(1, 1'b1, 1'b1, 3'b010, 32'h4, 32'h11111111);
        @(negedge clk);
        n_checks++;
        if (bus0.resp_valid !== 1'b1 || bus0.req_ready !== 1'b0 || bus0.rdata !== 32'hCAFEF00D) begin
            n_fail++;
            $display("FAIL zw_resp: got valid=%b ready=%b rdata=%h expected 1 0 cafef00d",
                     bus0.resp_valid, bus0.req_ready, bus0.rdata);
        end
        @(posedge clk); #1;
        drive(1, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
        @(negedge clk);
        n_checks++;
        if (bus0.req_ready !== 1'b1 || bus0.resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL zw_ignored: got ready=%b valid=%b expected 1 0", bus0.req_ready, bus0.resp_valid);
        end
        access(1, 1'b0, 3'b010, 32'h4, 32'h0, 32'hCAFEF00D, 1'b0, "zw_lw_unchanged");
    endtask

    task automatic test_reset_mid();
        bit seen;
        access(0, 1'b1, 3'b010, 32'h20, 32'h0, 32'h0, 1'b0, "sw_20_zero");
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 3'b010, 32'h20, 32'hFFFFFFFF);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        @(negedge clk);
        n_checks++;
        if (bus2.req_ready !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_wait: got ready=%b expected 0", bus2.req_ready);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (bus2.req_ready !== 1'b1 || bus2.resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_after: got ready=%b valid=%b expected 1 0", bus2.req_ready, bus2.resp_valid);
        end
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (bus2.resp_valid === 1'b1) seen = 1;
        end
        n_checks++;
        if (seen) begin
            n_fail++; $display("FAIL rst_mid_no_resp: got resp_valid=1 expected 0");
        end
        access(0, 1'b0, 3'b010, 32'h20, 32'h0, 32'h00000000, 1'b0, "lw_20_after_rst");
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte_lanes();
        test_wrap();
        test_illegal();
        test_misalign();
        test_back_to_back();
        test_zero_wait();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/data_mem_resp.md
# data_mem_resp

Data-memory responder for the RISC-V single-cycle core: the memory-side end of the load/store path driven by the control unit's `MemRW` and the instruction's funct3. It accepts one load or store request at a time and owns a word-organised data array. It performs byte/halfword/word lane selection with sign or zero extension and returns a one-cycle response after a programmable number of wait states, during which the core stalls.

## Interface
- `ADDR_WIDTH`, default 10: word-address bits; array depth is 2^ADDR_WIDTH 32-bit words.
- `WAIT_STATES`, default 2: extra cycles between acceptance and response; legal range 0..15.

- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: reset is synchronous and active-high.
- `req_valid` input 1: request present.
- `req_ready` output 1: block can accept a request.
- `MemRW` input 1: 1 = store, 0 = load.
- `funct3` input 3: access size and sign.
  - Loads: LB 000, LH 001, LW 010, LBU 100, LHU 101.
  - Stores: SB 000, SH 001, SW 010.
- `addr` input 32: byte address.
- `wdata` input 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `resp_valid` output 1: one-cycle response strobe.
- `rdata` output 32: extended load data.
- `misalign` output 1: qualifies `resp_valid`; access was misaligned.

## Operation
- States: IDLE, WAIT, RESP.
  - IDLE: `req_ready`=1. On `req_valid`, latch `MemRW`, `funct3`, `addr` and `wdata`.
    - Go to WAIT with counter = WAIT_STATES-1.
    - If WAIT_STATES = 0, go directly to RESP.
  - WAIT: `req_ready`=0. Counter decrements each cycle; go to RESP when it reaches 0.
  - RESP: `req_ready`=0 and `resp_valid`=1 for exactly one cycle, then unconditionally return to IDLE.
  - There is no response backpressure.
- Array index is `addr[ADDR_WIDTH+1:2]`. Upper address bits are ignored, so addresses wrap modulo the array size.
- Loads: lane selected by `addr[1:0]`.
  - LB/LBU: byte at lane `addr[1:0]`, sign-/zero-extended.
  - LH/LHU: half at `addr[1]`, sign-/zero-extended.
  - LW: full word.
- Stores: SB writes only the addressed byte lane, SH only the addressed half, SW all four lanes. Unwritten lanes are preserved.
- Store commit: the array write occurs on the edge that enters RESP.
- Load read: the array is sampled on the edge that enters RESP, so a store immediately preceding is visible.
- Illegal funct3:
  - load: `rdata`=0.
  - store: no write.
  - A response is still issued, with `misalign`=0.
- Store response: `rdata` = 0 for stores.
- Hold behaviour: `rdata` and `misalign` are registered and hold until the next response.
- Reset values:
  - state IDLE, counter 0.
  - `req_ready`=1, `resp_valid`=0, `rdata`=0, `misalign`=0.
  - Array contents are not reset.
- Reset mid-operation: the request is aborted with no response. A store not yet committed is never written.

## Timing
- Request accepted at edge N (`req_valid` & `req_ready`).
- `resp_valid` is high in cycle N+1+WAIT_STATES.
- `req_ready` returns high in the following cycle.
- Throughput: one access per WAIT_STATES+2 cycles.
- `req_valid` while `req_ready`=0 is ignored; the request inputs are not sampled.
- `rst` has priority over every transition.

## Configuration
- `MISALIGN_TRAP_EN` defined:
  - Halfword with `addr[0]`=1, or word with `addr[1:0]`≠0, is flagged as misaligned.
  - On such an access, `misalign`=1 with `resp_valid`, the store is suppressed, and `rdata`=0.
- `MISALIGN_TRAP_EN` undefined:
  - `misalign` is tied to 0.
  - Low address bits are forced aligned: halfword clears `addr[0]`, word clears `addr[1:0]`, and the access proceeds.

## Test plan
- **Store/load word:** WAIT_STATES=2. SW 0xDEADBEEF @0x10 then LW @0x10.
  - `resp_valid` 3 cycles after each acceptance.
  - `rdata`=0xDEADBEEF.
- **Byte lanes and extension:** after the SW above, SB 0x80 @0x13, then:
  - LB @0x13 -> 0xFFFFFF80; LBU @0x13 -> 0x00000080.
  - LHU @0x12 -> 0x000080AD; LH @0x10 -> 0xFFFFBEEF.
- **Wrap-around:** ADDR_WIDTH=10. SW 0x12345678 @0x1000, then LW @0x0000 -> 0x12345678.
- **Zero wait states:** WAIT_STATES=0. `resp_valid` in the cycle after acceptance; `req_ready` low for exactly 1 cycle. Also drive `req_valid` in that cycle and check it is ignored.
- **Misalignment:**
  - With `MISALIGN_TRAP_EN`: LW @0x11 -> `misalign`=1, `rdata`=0; SH @0x11 leaves the word unchanged.
  - Without the macro: LW @0x11 reads word 0x10, with `misalign`=0.
- **Reset mid-operation:** SW 0xFFFFFFFF @0x20 (word previously 0), assert `rst` during WAIT.
  - No `resp_valid`; `req_ready`=1 after the reset edge.
  - Subsequent LW @0x20 -> 0x00000000.
